spi_slave_frame_rx: RTL and testbench

SPI mode-0 slave front end that sits directly downstream of spi_master5 on the SS3 chip-select line, inside the slave TOP.
- Oversamples SCK/MOSI/CS in the system clock domain and deserialises MSB-first bytes.
- Tags the first byte of each frame as a command and queues all bytes in a small RX FIFO for the packet logic.
- Serialises a response byte stream onto MISO.

---
 rtl/spi_slave_pkg.sv | 29 ++
 rtl/spi_slave_frame_rx_if.sv | 42 ++++
 rtl/spi_slave_fifo.sv | 69 ++++++
 rtl/spi_slave_frame_rx.sv | 219 +++++++++++++++++++++
 tb/tb_spi_slave_frame_rx.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_pkg.sv
// Shared constants, state encoding, RX FIFO entry layout and CRC-8 helper
// for the SPI mode-0 frame receiver.
package spi_slave_pkg;

    localparam int unsigned SPI_BITS  = 8;
    localparam logic [7:0]  CRC8_POLY = 8'h07;
    localparam logic [7:0]  CRC8_INIT = 8'h00;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef struct packed {
        logic [SPI_BITS-1:0] data;
        logic                is_cmd;
    } rx_entry_t;

    // One MSB-first CRC-8 byte step.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] din);
        logic [7:0] c;
        c = crc ^ din;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/spi_slave_frame_rx_if.sv
// Packet-logic side of the SPI frame receiver: RX FIFO head, TX byte feed,
// frame status. crc_ok exists only when SPI_SLAVE_CRC8_EN is defined.
interface spi_slave_frame_rx_if;
    import spi_slave_pkg::*;

    logic [SPI_BITS-1:0] rx_data;
    logic                rx_is_cmd;
    logic                rx_empty;
    logic                rd_en;
    logic [SPI_BITS-1:0] tx_data;
    logic                tx_taken;
    logic                frame_active;
    logic                frame_done;
    logic                byte_err;
    logic                ovf;
    logic                clr_ovf;
`ifdef SPI_SLAVE_CRC8_EN
    logic                crc_ok;

    modport slave (
        output rx_data, rx_is_cmd, rx_empty, tx_taken, frame_active,
               frame_done, byte_err, ovf, crc_ok,
        input  rd_en, tx_data, clr_ovf
    );
    modport master (
        input  rx_data, rx_is_cmd, rx_empty, tx_taken, frame_active,
               frame_done, byte_err, ovf, crc_ok,
        output rd_en, tx_data, clr_ovf
    );
`else
    modport slave (
        output rx_data, rx_is_cmd, rx_empty, tx_taken, frame_active,
               frame_done, byte_err, ovf,
        input  rd_en, tx_data, clr_ovf
    );
    modport master (
        input  rx_data, rx_is_cmd, rx_empty, tx_taken, frame_active,
               frame_done, byte_err, ovf,
        output rd_en, tx_data, clr_ovf
    );
`endif
endinterface

// File: rtl/spi_slave_fifo.sv
// First-word-fall-through RX FIFO of {byte, is_cmd} entries. A push into a
// full FIFO is dropped (drop_c) unless a pop frees the slot in the same cycle.
module spi_slave_fifo
    import spi_slave_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  rx_entry_t push_data_i,
    input  logic      pop_i,
    output rx_entry_t head_o,
    output logic      empty_o,
    output logic      drop_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    rx_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            empty_q;
    logic            full;
    logic            push_ok;
    logic            pop_ok;

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        pop_ok  = pop_i & ~empty_q;
        push_ok = push_i & (~full | pop_ok);
        drop_c  = push_i & ~push_ok;
        count_d = count_q;
        if (push_ok & ~pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok & ~push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = empty_q;

endmodule

// File: rtl/spi_slave_frame_rx.sv
// SPI mode-0 slave front end: oversampled SCK/MOSI/CS, MSB-first byte RX into a
// FIFO with command tagging, MISO response shifter. Optional CRC-8 check: SPI_SLAVE_CRC8_EN.
module spi_slave_frame_rx
    import spi_slave_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SCK,
    input  logic                 MOSI,
    input  logic                 CS,
    output logic                 MISO,
    spi_slave_frame_rx_if.slave  bus
);

    localparam int unsigned        CNT_W    = $clog2(SPI_BITS);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(SPI_BITS - 1);

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   sck_prev_q;
    logic                   cs_prev_q;

    // CS synchroniser resets high so reset looks like "no frame".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    logic sck_s, mosi_s, cs_s;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_rise =  sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s &  sck_prev_q;
    assign cs_rise  =  cs_s  & ~cs_prev_q;
    assign cs_fall  = ~cs_s  &  cs_prev_q;

    state_t              state_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic                first_q;
    logic                load_pend_q;
    logic [SPI_BITS-1:0] rx_shift_q;
    logic [SPI_BITS-1:0] rx_shift_d;
    logic [SPI_BITS-1:0] tx_shift_q;
    logic                push_q;
    rx_entry_t           push_data_q;
    logic                tx_taken_q;
    logic                frame_active_q;
    logic                frame_done_q;
    logic                byte_err_q;
    logic                byte_done;

    assign rx_shift_d = {rx_shift_q[SPI_BITS-2:0], mosi_s};
    assign byte_done  = sck_rise & (bit_cnt_q == LAST_BIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            first_q        <= 1'b0;
            load_pend_q    <= 1'b0;
            rx_shift_q     <= '0;
            tx_shift_q     <= '0;
            push_q         <= 1'b0;
            push_data_q    <= '0;
            tx_taken_q     <= 1'b0;
            frame_active_q <= 1'b0;
            frame_done_q   <= 1'b0;
            byte_err_q     <= 1'b0;
        end else begin
            push_q       <= 1'b0;
            tx_taken_q   <= 1'b0;
            frame_done_q <= 1'b0;
            byte_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q        <= SHIFT;
                        bit_cnt_q      <= '0;
                        first_q        <= 1'b1;
                        load_pend_q    <= 1'b0;
                        tx_shift_q     <= bus.tx_data;
                        tx_taken_q     <= 1'b1;
                        frame_active_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (sck_rise) begin
                        rx_shift_q <= rx_shift_d;
                        if (byte_done) begin
                            push_q      <= 1'b1;
                            push_data_q <= '{data: rx_shift_d, is_cmd: first_q};
                            first_q     <= 1'b0;
                            bit_cnt_q   <= '0;
                            load_pend_q <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                    // A byte completing on the CS-rise cycle is kept; anything shorter is dropped.
                    if (cs_rise) begin
                        state_q        <= IDLE;
                        frame_active_q <= 1'b0;
                        frame_done_q   <= 1'b1;
                        byte_err_q     <= ~byte_done & (sck_rise | (bit_cnt_q != '0));
                        bit_cnt_q      <= '0;
                        load_pend_q    <= 1'b0;
                        tx_shift_q     <= '0;
                    end else if (sck_fall) begin
                        if (load_pend_q) begin
                            tx_shift_q  <= bus.tx_data;
                            tx_taken_q  <= 1'b1;
                            load_pend_q <= 1'b0;
                        end else begin
                            tx_shift_q <= {tx_shift_q[SPI_BITS-2:0], 1'b0};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SPI_SLAVE_CRC8_EN
    logic [7:0] crc_q;
    logic [7:0] crc_d;
    logic [1:0] nbytes_q;
    logic [1:0] nbytes_d;
    logic       crc_ok_q;

    // Byte count saturates at 2: only "at least two bytes" matters.
    always_comb begin
        crc_d    = crc_q;
        nbytes_d = nbytes_q;
        if (byte_done) begin
            crc_d = crc8_byte(crc_q, rx_shift_d);
            if (nbytes_q != 2'd2) begin
                nbytes_d = nbytes_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q    <= CRC8_INIT;
            nbytes_q <= '0;
            crc_ok_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (cs_fall) begin
                crc_q    <= CRC8_INIT;
                nbytes_q <= '0;
            end
        end else begin
            crc_q    <= crc_d;
            nbytes_q <= nbytes_d;
            if (cs_rise) begin
                crc_ok_q <= (crc_d == 8'h00) && (nbytes_d == 2'd2);
            end
        end
    end

    assign bus.crc_ok = crc_ok_q;
`endif

    rx_entry_t head;
    logic      fifo_empty;
    logic      drop_c;
    logic      ovf_q;

    spi_slave_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_q),
        .push_data_i (push_data_q),
        .pop_i       (bus.rd_en),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .drop_c      (drop_c)
    );

    // A new drop outranks a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= drop_c | (ovf_q & ~bus.clr_ovf);
        end
    end

    assign MISO             = tx_shift_q[SPI_BITS-1];
    assign bus.rx_data      = head.data;
    assign bus.rx_is_cmd    = head.is_cmd;
    assign bus.rx_empty     = fifo_empty;
    assign bus.tx_taken     = tx_taken_q;
    assign bus.frame_active = frame_active_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.byte_err     = byte_err_q;
    assign bus.ovf          = ovf_q;

endmodule

// File: tb/tb_spi_slave_frame_rx.sv
// Directed bench for spi_slave_frame_rx: bit-banged SPI master, FIFO drain and
// pulse counters; CRC steps only when SPI_SLAVE_CRC8_EN is defined.
module tb_spi_slave_frame_rx;
    import spi_slave_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic SCK;
    logic MOSI;
    logic CS;
    logic MISO;

    spi_slave_frame_rx_if bus ();

    always #5 clk = ~clk;

    spi_slave_frame_rx #(
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .SCK  (SCK),
        .MOSI (MOSI),
        .CS   (CS),
        .MISO (MISO),
        .bus  (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   fd_cnt = 0;
    int   be_cnt = 0;
    int   tt_cnt = 0;
    logic crc_seen = 1'b0;

    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) fd_cnt++;
        if (bus.byte_err   === 1'b1) be_cnt++;
        if (bus.tx_taken   === 1'b1) tt_cnt++;
`ifdef SPI_SLAVE_CRC8_EN
        if (bus.frame_done === 1'b1) crc_seen = bus.crc_ok;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode 0: MOSI set while SCK low, MISO sampled just before the rising edge.
    task automatic spi_bits(input logic [7:0] val, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            MOSI = val[7-i];
            wait_clk(6);
            rx  = {rx[6:0], MISO};
            SCK = 1'b1;
            wait_clk(6);
            SCK = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] val);
        logic [7:0] dummy;
        spi_bits(val, 8, dummy);
    endtask

    task automatic cs_low();
        CS = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_high();
        wait_clk(6);
        CS = 1'b1;
        wait_clk(8);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] d, input logic c);
        chk({tag, "_empty"}, 32'(bus.rx_empty), 32'd0);
        chk({tag, "_data"}, 32'(bus.rx_data), 32'(d));
        chk({tag, "_cmd"}, 32'(bus.rx_is_cmd), 32'(c));
        bus.rd_en = 1'b1;
        wait_clk(1);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        rst         = 1'b1;
        CS          = 1'b1;
        SCK         = 1'b0;
        MOSI        = 1'b0;
        bus.rd_en   = 1'b0;
        bus.tx_data = 8'h00;
        bus.clr_ovf = 1'b0;
        wait_clk(3);
        chk("rst_empty", 32'(bus.rx_empty), 32'd1);
        chk("rst_data", 32'(bus.rx_data), 32'd0);
        chk("rst_cmd", 32'(bus.rx_is_cmd), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_active", 32'(bus.frame_active), 32'd0);
        chk("rst_miso", 32'(MISO), 32'd0);
        chk("rst_taken", 32'(bus.tx_taken), 32'd0);
        rst = 1'b0;
        wait_clk(4);

        // Two-byte frame with response bytes 0x96, 0x5A
        bus.tx_data = 8'h96;
        cs_low();
        chk("a_active", 32'(bus.frame_active), 32'd1);
        chk("a_taken1", 32'(tt_cnt), 32'd1);
        bus.tx_data = 8'h5A;
        spi_bits(8'hA5, 8, r);
        chk("a_miso0", 32'(r), 32'h96);
        wait_clk(4);
        chk("a_taken2", 32'(tt_cnt), 32'd2);
        spi_bits(8'h3C, 8, r);
        chk("a_miso1", 32'(r), 32'h5A);
        cs_high();
        chk("a_done", 32'(fd_cnt), 32'd1);
        chk("a_berr", 32'(be_cnt), 32'd0);
        chk("a_inactive", 32'(bus.frame_active), 32'd0);
        chk("a_miso_idle", 32'(MISO), 32'd0);
        pop_chk("a0", 8'hA5, 1'b1);
        pop_chk("a1", 8'h3C, 1'b0);
        chk("a_drained", 32'(bus.rx_empty), 32'd1);

        // Aborted frame: 5 bits then CS rise
        cs_low();
        spi_bits(8'hFF, 5, r);
        cs_high();
        chk("p_berr", 32'(be_cnt), 32'd1);
        chk("p_done", 32'(fd_cnt), 32'd2);
        chk("p_empty", 32'(bus.rx_empty), 32'd1);
        cs_low();
        send(8'h11);
        send(8'h22);
        cs_high();
        chk("p_berr2", 32'(be_cnt), 32'd1);
        pop_chk("p0", 8'h11, 1'b1);
        pop_chk("p1", 8'h22, 1'b0);

        // Overflow: 5 bytes into a 4-deep FIFO
        cs_low();
        for (int i = 1; i <= 5; i++) send(8'(i));
        cs_high();
        chk("o_ovf", 32'(bus.ovf), 32'd1);
        pop_chk("o0", 8'h01, 1'b1);
        pop_chk("o1", 8'h02, 1'b0);
        pop_chk("o2", 8'h03, 1'b0);
        pop_chk("o3", 8'h04, 1'b0);
        chk("o_empty", 32'(bus.rx_empty), 32'd1);
        chk("o_sticky", 32'(bus.ovf), 32'd1);
        bus.clr_ovf = 1'b1;
        wait_clk(1);
        bus.clr_ovf = 1'b0;
        wait_clk(1);
        chk("o_clr", 32'(bus.ovf), 32'd0);

        // Full FIFO, pop in the push cycle of the 5th byte (rise seen 3 clk later, push 1 clk after)
        cs_low();
        send(8'h10);
        send(8'h20);
        send(8'h30);
        send(8'h40);
        spi_bits(8'h50, 7, r);
        MOSI = 1'b0;
        wait_clk(6);
        SCK = 1'b1;
        wait_clk(3);
        bus.rd_en = 1'b1;
        wait_clk(1);
        bus.rd_en = 1'b0;
        wait_clk(2);
        SCK = 1'b0;
        cs_high();
        chk("f_ovf", 32'(bus.ovf), 32'd0);
        pop_chk("f0", 8'h20, 1'b0);
        pop_chk("f1", 8'h30, 1'b0);
        pop_chk("f2", 8'h40, 1'b0);
        pop_chk("f3", 8'h50, 1'b0);
        chk("f_empty", 32'(bus.rx_empty), 32'd1);
        chk("f_done", 32'(fd_cnt), 32'd5);

`ifdef SPI_SLAVE_CRC8_EN
        // crc8(0x01,0x02) = 0x1B
        cs_low();
        send(8'h01);
        send(8'h02);
        send(8'h1B);
        cs_high();
        chk("c_ok", 32'(crc_seen), 32'd1);
        pop_chk("c0", 8'h01, 1'b1);
        pop_chk("c1", 8'h02, 1'b0);
        pop_chk("c2", 8'h1B, 1'b0);
        cs_low();
        send(8'h01);
        send(8'h02);
        send(8'h00);
        cs_high();
        chk("c_bad", 32'(crc_seen), 32'd0);
        pop_chk("c3", 8'h01, 1'b1);
        pop_chk("c4", 8'h02, 1'b0);
        pop_chk("c5", 8'h00, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
